nibble_alu_sequencer: RTL and testbench

- Initiator side of the 4-bit nibble adder en/ready handshake.
- Performs WIDTH-bit add or subtract by issuing WIDTH/4 sequential nibble operations, LSB nibble first, to an external 4-bit adder. Carry ripples between passes through a register.
- Sits between the datapath controller (start/done) and the nibble adder, so the 8-bit machine reuses one 4-bit adder.

---
 rtl/nibble_alu_sequencer_pkg.sv | 17 +
 rtl/nibble_alu_sequencer.sv | 141 ++++++++++++++
 tb/tb_nibble_alu_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_alu_sequencer_pkg.sv
// Shared types and constants for the nibble ALU sequencer.
// Holds the FSM state encoding and the add/sub opcode values.
package nibble_alu_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP,
        DONE
    } state_e;

    localparam int NIBBLE_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/nibble_alu_sequencer.sv
// Sequences a WIDTH-bit add/sub as LSB-first nibble passes
// through one external 4-bit adder over an en/ready handshake.
module nibble_alu_sequencer #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             err,
    output logic             busy,
    output logic             done,
    output logic             add_en,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout,
    input  logic             add_ready
);
    import nibble_alu_sequencer_pkg::*;

    localparam int NIBS  = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam int MSB   = WIDTH - 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cy_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] wait_cnt;

    logic accept;
    logic nib_wr;
    logic nib_adv;
    logic to_err;
    logic enter_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        nib_wr  = 1'b0;
        nib_adv = 1'b0;
        to_err  = 1'b0;
        busy    = (state_q != IDLE);
        done    = 1'b0;
        add_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                add_en = 1'b1;
                if (add_ready) begin
                    nib_wr  = 1'b1;
                    state_d = GAP;
                end else if (wait_cnt == LAST_CNT) begin
                    to_err  = 1'b1;
                    state_d = DONE;
                end
            end
            GAP: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    nib_adv = 1'b1;
                    state_d = ISSUE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign enter_done = (state_d == DONE) && (state_q != DONE);

    assign add_a   = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
    assign add_b   = b_q[NIBBLE_W*idx_q +: NIBBLE_W];
    assign add_cin = cy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            cy_q     <= 1'b0;
            idx_q    <= '0;
            wait_cnt <= '0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (accept) begin
                a_q    <= a;
                b_q    <= (op == OP_ADD) ? b : ~b;
                cy_q   <= (op == OP_SUB);
                idx_q  <= '0;
                result <= '0;
                err    <= 1'b0;
            end
            if (state_q == ISSUE) wait_cnt <= wait_cnt + 1'b1;
            else                  wait_cnt <= '0;
            if (nib_wr) begin
                result[NIBBLE_W*idx_q +: NIBBLE_W] <= add_sum;
                cy_q <= add_cout;
            end
            if (nib_adv) idx_q <= idx_q + 1'b1;
            if (to_err)  err   <= 1'b1;
            // Result is already final on the GAP->DONE edge; a timeout never flags overflow.
            if (enter_done) begin
                carry    <= cy_q;
                overflow <= !to_err && (a_q[MSB] == b_q[MSB])
                            && (result[MSB] != a_q[MSB]);
            end
        end
    end

endmodule

// File: tb/tb_nibble_alu_sequencer.sv
// Directed bench for nibble_alu_sequencer with a 4-bit adder
// model whose ready delay is programmable.
module tb_nibble_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] result;
    logic       carry;
    logic       overflow;
    logic       err;
    logic       busy;
    logic       done;
    logic       add_en;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic       add_cin;
    logic [3:0] add_sum;
    logic       add_cout;
    logic       add_ready;

    int checks = 0;
    int errors = 0;

    int dly   = 0;
    bit never = 1'b0;
    int scnt  = 0;

    logic       en_h[$];
    logic [3:0] aa_h[$];
    logic [3:0] bb_h[$];
    logic       ci_h[$];

    nibble_alu_sequencer #(.WIDTH(8), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .result(result), .carry(carry),
        .overflow(overflow), .err(err), .busy(busy), .done(done),
        .add_en(add_en), .add_a(add_a), .add_b(add_b),
        .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
        .add_ready(add_ready)
    );

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    always @(posedge clk) begin
        if (!add_en) scnt <= 0;
        else         scnt <= scnt + 1;
    end

    assign add_ready = add_en && !never && (scnt >= dly);

    task automatic launch(input logic [7:0] ia, input logic [7:0] ib, input logic iop);
        @(negedge clk);
        a = ia; b = ib; op = iop; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        en_h.delete(); aa_h.delete(); bb_h.delete(); ci_h.delete();
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            en_h.push_back(add_en); aa_h.push_back(add_a);
            bb_h.push_back(add_b);  ci_h.push_back(add_cin);
            if (done) begin
                cyc = i;
                return;
            end
        end
        cyc = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({result, carry, overflow, err, busy, done, add_en} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outs got %h%b%b%b%b%b%b want 0", result, carry, overflow, err, busy, done, add_en);
        end
        checks++;
        if ({add_a, add_b, add_cin} !== 9'd0) begin
            errors++;
            $display("FAIL reset_adder got %h %h %b want 0", add_a, add_b, add_cin);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_add();
        int cyc;
        launch(8'h3C, 8'h45, 1'b0);
        wait_done(cyc);
        checks++;
        if (cyc !== 5) begin errors++; $display("FAIL add_latency got %0d want 5", cyc); end
        checks++;
        if (result !== 8'h81) begin errors++; $display("FAIL add_result got %h want 81", result); end
        checks++;
        if ({carry, overflow, err} !== 3'b010) begin
            errors++; $display("FAIL add_flags got c%b v%b e%b want c0 v1 e0", carry, overflow, err);
        end
        checks++;
        if ({en_h[0], en_h[1], en_h[2], en_h[3]} !== 4'b1010) begin
            errors++; $display("FAIL add_en_gap got %b%b%b%b want 1010", en_h[0], en_h[1], en_h[2], en_h[3]);
        end
        checks++;
        if ({aa_h[0], bb_h[0], aa_h[2], bb_h[2]} !== 16'hC534) begin
            errors++; $display("FAIL add_nibbles got %h%h%h%h want c534", aa_h[0], bb_h[0], aa_h[2], bb_h[2]);
        end
    endtask

    task automatic test_carry_chain();
        int cyc;
        launch(8'hFF, 8'h01, 1'b0);
        wait_done(cyc);
        checks++;
        if (result !== 8'h00) begin errors++; $display("FAIL cy_result got %h want 00", result); end
        checks++;
        if ({carry, overflow} !== 2'b10) begin
            errors++; $display("FAIL cy_flags got c%b v%b want c1 v0", carry, overflow);
        end
        checks++;
        if ({ci_h[0], ci_h[2]} !== 2'b01) begin
            errors++; $display("FAIL cy_cin got %b%b want 01", ci_h[0], ci_h[2]);
        end
    endtask

    task automatic test_subtract();
        int cyc;
        launch(8'h10, 8'h20, 1'b1);
        wait_done(cyc);
        checks++;
        if (result !== 8'hF0) begin errors++; $display("FAIL sub1_result got %h want f0", result); end
        checks++;
        if ({carry, overflow} !== 2'b00) begin
            errors++; $display("FAIL sub1_flags got c%b v%b want c0 v0", carry, overflow);
        end
        checks++;
        if ({ci_h[0], bb_h[0], bb_h[2]} !== 9'b1_1111_1101) begin
            errors++; $display("FAIL sub1_inv got cin%b b%h b%h want cin1 bf bd", ci_h[0], bb_h[0], bb_h[2]);
        end
        launch(8'h80, 8'h01, 1'b1);
        wait_done(cyc);
        checks++;
        if (result !== 8'h7F) begin errors++; $display("FAIL sub2_result got %h want 7f", result); end
        checks++;
        if ({carry, overflow} !== 2'b11) begin
            errors++; $display("FAIL sub2_flags got c%b v%b want c1 v1", carry, overflow);
        end
    endtask

    task automatic test_delayed_ready();
        int cyc;
        dly = 2;
        launch(8'h12, 8'h34, 1'b0);
        start = 1'b1; a = 8'hFF; b = 8'hFF;
        wait_done(cyc);
        start = 1'b0;
        checks++;
        if (cyc !== 9) begin errors++; $display("FAIL dly_latency got %0d want 9", cyc); end
        checks++;
        if (result !== 8'h46) begin errors++; $display("FAIL dly_result got %h want 46", result); end
        checks++;
        if ({aa_h[0], aa_h[1], aa_h[2], bb_h[0], bb_h[1], bb_h[2]} !== 24'h222444) begin
            errors++; $display("FAIL dly_stable0 got a%h%h%h b%h%h%h want a222 b444",
                aa_h[0], aa_h[1], aa_h[2], bb_h[0], bb_h[1], bb_h[2]);
        end
        checks++;
        if ({aa_h[4], aa_h[6], bb_h[4], bb_h[6], en_h[3], en_h[6]} !== 18'b0001_0001_0011_0011_01) begin
            errors++; $display("FAIL dly_stable1 got a%h%h b%h%h en%b%b want a11 b33 en01",
                aa_h[4], aa_h[6], bb_h[4], bb_h[6], en_h[3], en_h[6]);
        end
        @(negedge clk);
        checks++;
        if ({busy, done, result} !== {2'b00, 8'h46}) begin
            errors++; $display("FAIL busy_start_ignored got busy%b done%b r%h want busy0 done0 r46", busy, done, result);
        end
        dly = 0;
    endtask

    task automatic test_timeout();
        int cyc;
        never = 1'b1;
        launch(8'h55, 8'h11, 1'b0);
        wait_done(cyc);
        checks++;
        if (cyc !== 65) begin errors++; $display("FAIL to_latency got %0d want 65", cyc); end
        checks++;
        if ({err, overflow, result} !== {2'b10, 8'h00}) begin
            errors++; $display("FAIL to_state got e%b v%b r%h want e1 v0 r00", err, overflow, result);
        end
        @(negedge clk);
        checks++;
        if ({busy, done, err} !== 3'b001) begin
            errors++; $display("FAIL to_after got busy%b done%b e%b want busy0 done0 e1", busy, done, err);
        end
        never = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        int cyc;
        bit saw_done;
        launch(8'h37, 8'h25, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if ({add_en, result} !== {1'b1, 8'h0C}) begin
            errors++; $display("FAIL rst_pre got en%b r%h want en1 r0c", add_en, result);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({add_en, busy, result} !== 10'd0) begin
            errors++; $display("FAIL rst_immediate got en%b busy%b r%h want 0", add_en, busy, result);
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin errors++; $display("FAIL rst_no_done got %b want 0", saw_done); end
        launch(8'h01, 8'h01, 1'b0);
        wait_done(cyc);
        checks++;
        if ({cyc == 5, result} !== {1'b1, 8'h02}) begin
            errors++; $display("FAIL rst_recover got cyc%0d r%h want cyc5 r02", cyc, result);
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_carry_chain();
        test_subtract();
        test_delayed_ready();
        test_timeout();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
